// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle RV32I sequencer.
package mc_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  // Major opcodes, IR[6:2]
  localparam logic [4:0] OP_R      = 5'b01100;
  localparam logic [4:0] OP_I      = 5'b00100;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLT  = 4'd2;
  localparam logic [3:0] ALU_SLTU = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_AND  = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_LSU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;

  // Static controls derived from the instruction register alone
  typedef struct packed {
    logic       legal;
    logic [3:0] alu_op;
    logic       opa_sel;
    logic       opb_sel;
    logic [1:0] wb_sel;
    logic       br_un;
    logic       br_f3_ok;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       is_jump;
    logic       rd_wr;
  } dec_t;

  // ALU op for OP/OP-IMM; IR[30] selects SUB only for register ops,
  // and selects SRA for both register and immediate shifts.
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3,
                                             input logic       alt,
                                             input logic       is_reg);
    case (f3)
      3'b000:  return (is_reg && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational decode of the instruction register into static datapath controls.
module mc_decode
  import mc_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [4:0] opc;
  logic [2:0] f3;
  logic       alt;

  assign opc = instr[6:2];
  assign f3  = instr[14:12];
  assign alt = instr[30];

  // Unknown opcodes leave every control at zero with legal=0
  always_comb begin
    dec = '0;
    case (opc)
      OP_R: begin
        dec.legal  = 1'b1;
        dec.alu_op = alu_from_f3(f3, alt, 1'b1);
        dec.rd_wr  = 1'b1;
      end
      OP_I: begin
        dec.legal   = 1'b1;
        dec.alu_op  = alu_from_f3(f3, alt, 1'b0);
        dec.opb_sel = 1'b1;
        dec.rd_wr   = 1'b1;
      end
      OP_LOAD: begin
        dec.legal   = 1'b1;
        dec.opb_sel = 1'b1;
        dec.wb_sel  = WB_LSU;
        dec.is_load = 1'b1;
        dec.rd_wr   = 1'b1;
      end
      OP_STORE: begin
        dec.legal    = 1'b1;
        dec.opb_sel  = 1'b1;
        dec.is_store = 1'b1;
      end
      OP_BRANCH: begin
        // ALU forms the target PC+imm while the comparator decides
        dec.legal     = 1'b1;
        dec.opa_sel   = 1'b1;
        dec.opb_sel   = 1'b1;
        dec.br_un     = (f3[2:1] == 2'b11);
        dec.br_f3_ok  = (f3[2:1] != 2'b01);
        dec.is_branch = 1'b1;
      end
      OP_JAL: begin
        dec.legal   = 1'b1;
        dec.opa_sel = 1'b1;
        dec.opb_sel = 1'b1;
        dec.wb_sel  = WB_PC4;
        dec.is_jump = 1'b1;
        dec.rd_wr   = 1'b1;
      end
      OP_JALR: begin
        dec.legal   = 1'b1;
        dec.opb_sel = 1'b1;
        dec.wb_sel  = WB_PC4;
        dec.is_jump = 1'b1;
        dec.rd_wr   = 1'b1;
      end
      OP_LUI: begin
        // Result comes straight from the immediate; ALU just sees rs1+imm
        dec.legal   = 1'b1;
        dec.opb_sel = 1'b1;
        dec.wb_sel  = WB_IMM;
        dec.rd_wr   = 1'b1;
      end
      OP_AUIPC: begin
        dec.legal   = 1'b1;
        dec.opa_sel = 1'b1;
        dec.opb_sel = 1'b1;
        dec.rd_wr   = 1'b1;
      end
      default: dec = '0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I datapath.
// Handshake: a request (o_imem_req / o_dmem_req) is held high for the whole
// FETCH / MEM state; the access completes on the rising edge where the
// matching ack is high. On the TIMEOUT-th waiting cycle the access is
// abandoned: o_bus_err pulses and an ack arriving in that same cycle is
// ignored, so every output depends only on registered state.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int          TIMEOUT = 16,
  parameter logic [31:0] NOP     = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_instr,
  input  logic        i_br_less,
  input  logic        i_br_equal,
  output logic        o_br_un,
  output logic        o_pc_sel,
  output logic        o_pc_wren,
  output logic        o_rd_wren,
  output logic        o_opa_sel,
  output logic        o_opb_sel,
  output logic [3:0]  o_alu_op,
  output logic [1:0]  o_wb_sel,
  output logic        o_dmem_req,
  output logic        o_mem_wren,
  input  logic        i_dmem_ack,
  output logic        o_insn_vld,
  output logic        o_illegal,
  output logic        o_bus_err,
  output logic [31:0] o_instret,
  output state_t      o_dbg_state
);

  localparam int            CW      = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  state_t        state;
  logic [31:0]   ir;
  logic [31:0]   instret;
  logic [CW-1:0] wait_cnt;
  logic          taken;
  logic          abort;
  logic          active;   // low for the first cycle after reset release
  logic          deadline;
  logic          br_cond;
  dec_t          dec;

  mc_decode u_decode (
    .instr (ir),
    .dec   (dec)
  );

  assign deadline = (wait_cnt == CNT_MAX);

  // Branch outcome from the comparator flags and funct3
  always_comb begin
    br_cond = 1'b0;
    case (ir[14:12])
      3'b000:         br_cond = i_br_equal;
      3'b001:         br_cond = !i_br_equal;
      3'b100, 3'b110: br_cond = i_br_less;
      3'b101, 3'b111: br_cond = !i_br_less;
      default:        br_cond = 1'b0;
    endcase
  end

  // Sequencer: state, instruction register, wait counter, flags, instret
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= S_FETCH;
      ir       <= NOP;
      instret  <= '0;
      wait_cnt <= '0;
      taken    <= 1'b0;
      abort    <= 1'b0;
      active   <= 1'b0;
    end else begin
      active <= 1'b1;
      case (state)
        S_FETCH: begin
          if (active) begin
            if (deadline) begin
              wait_cnt <= '0;            // retry the same PC
            end else if (i_imem_ack) begin
              ir       <= i_imem_rdata;
              wait_cnt <= '0;
              state    <= S_DECODE;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
        end
        S_DECODE: begin
          if (!dec.legal) begin
            abort <= 1'b1;
            state <= S_WB;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (dec.is_branch) begin
            if (!dec.br_f3_ok) abort <= 1'b1;
            else               taken <= br_cond;
            state <= S_WB;
          end else if (dec.is_load || dec.is_store) begin
            wait_cnt <= '0;
            state    <= S_MEM;
          end else begin
            state <= S_WB;
          end
        end
        S_MEM: begin
          if (deadline) begin
            wait_cnt <= '0;
            abort    <= 1'b1;
            state    <= S_WB;
          end else if (i_dmem_ack) begin
            wait_cnt <= '0;
            state    <= S_WB;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_WB: begin
          if (!abort) instret <= instret + 32'd1;
          abort <= 1'b0;
          taken <= 1'b0;
          state <= S_FETCH;
        end
        default: state <= S_FETCH;
      endcase
    end
  end

  // Datapath controls decoded from state and IR only
  always_comb begin
    o_imem_req = 1'b0;
    o_br_un    = 1'b0;
    o_pc_sel   = 1'b0;
    o_pc_wren  = 1'b0;
    o_rd_wren  = 1'b0;
    o_opa_sel  = 1'b0;
    o_opb_sel  = 1'b0;
    o_alu_op   = ALU_ADD;
    o_wb_sel   = WB_ALU;
    o_dmem_req = 1'b0;
    o_mem_wren = 1'b0;
    o_insn_vld = 1'b0;
    o_illegal  = 1'b0;
    o_bus_err  = 1'b0;
    case (state)
      S_FETCH: begin
        o_imem_req = active;
        o_bus_err  = active && deadline;
      end
      S_DECODE: begin
        o_illegal = !dec.legal;
      end
      S_EXEC: begin
        o_alu_op  = dec.alu_op;
        o_opa_sel = dec.opa_sel;
        o_opb_sel = dec.opb_sel;
        o_br_un   = dec.br_un;
        o_illegal = dec.is_branch && !dec.br_f3_ok;
      end
      S_MEM: begin
        o_dmem_req = 1'b1;
        o_mem_wren = dec.is_store;
        o_opb_sel  = 1'b1;          // address = rs1 + imm
        o_bus_err  = deadline;
      end
      S_WB: begin
        o_alu_op   = dec.alu_op;
        o_opa_sel  = dec.opa_sel;
        o_opb_sel  = dec.opb_sel;
        o_wb_sel   = dec.wb_sel;
        o_pc_wren  = 1'b1;
        o_pc_sel   = !abort && (dec.is_jump || taken);
        o_rd_wren  = !abort && dec.rd_wr;
        o_insn_vld = !abort;
      end
      default: ;
    endcase
  end

  assign o_instr     = ir;
  assign o_instret   = instret;
  assign o_dbg_state = state;

endmodule

// File: doc/mc_ctrl.md
Name:
mc_ctrl

Overview:
Multi-cycle sequencer that converts the RV32I core from single-cycle to multi-cycle operation over one shared-latency memory interface. It fetches into an internal instruction register, then steps FETCH/DECODE/EXEC/MEM/WB, driving the existing datapath controls (ALU op, operand selects, writeback select, branch compare mode, PC/regfile/memory enables) once per state. It also counts retired instructions and times out stalled memory handshakes.

Parameters:
TIMEOUT, 16, max cycles waiting for i_imem_ack/i_dmem_ack before abort (>=2)
NOP, 32'h0000_0013, IR reset value (addi x0,x0,0)

Ports:
i_clk in 1 clock, rising edge
i_rst_n in 1 asynchronous active-low reset
o_imem_req out 1 instruction fetch request, held until ack
i_imem_ack in 1 fetch data valid this cycle
i_imem_rdata in 32 fetched instruction
o_instr out 32 instruction register, to regfile/immgen
i_br_less in 1 rs1<rs2 from branch comparator
i_br_equal in 1 rs1==rs2
o_br_un out 1 1=unsigned compare
o_pc_sel out 1 1=PC<-ALU result, 0=PC+4
o_pc_wren out 1 PC update strobe
o_rd_wren out 1 regfile write strobe
o_opa_sel out 1 0=rs1, 1=PC
o_opb_sel out 1 0=rs2, 1=imm
o_alu_op out 4 ADD0 SUB1 SLT2 SLTU3 XOR4 OR5 AND6 SLL7 SRL8 SRA9
o_wb_sel out 2 00 ALU, 01 LSU, 10 PC+4, 11 imm
o_dmem_req out 1 load/store request, held until ack
o_mem_wren out 1 store qualifier, valid with o_dmem_req
i_dmem_ack in 1 data access complete
o_insn_vld out 1 one-cycle pulse per retired instruction
o_illegal out 1 one-cycle pulse, unknown opcode
o_bus_err out 1 one-cycle pulse, handshake timeout
o_instret out 32 retired-instruction count, wraps

Behaviour:
- Reset (async, asserted): state FETCH, IR=NOP, instret=0, wait counter=0, taken/abort flags=0; all 1-bit outputs 0, o_alu_op=0, o_wb_sel=0. o_imem_req rises first cycle after release.
- Outputs are decoded from registered state+IR only (no input-to-output paths except none); stable within a state.
- FETCH: o_imem_req=1. On i_imem_ack: IR<-i_imem_rdata, ->DECODE (zero-wait ack allowed same cycle). Wait counter reaching TIMEOUT-1 without ack: o_bus_err pulse, counter clears, stay FETCH (retry same PC).
- DECODE: opcode IR[6:2]; legal set 01100,00100,00000,01000,11000,11011,11001,01101,00101. Illegal: o_illegal pulse, abort=1 ->WB.
- EXEC: ALU controls per IR; R/I shifts and SUB use IR[30], ADDI ignores IR[30]. Branch: br_un=1 for funct3 11x; taken = BEQ eq, BNE !eq, BLT/BLTU less, BGE/BGEU !less, other funct3 -> illegal handling; taken registered at end of EXEC. Load/store ->MEM, else ->WB.
- MEM: o_dmem_req=1, o_mem_wren=1 for stores; opa=rs1, opb=imm, alu ADD held. Ack ->WB. Timeout as FETCH but sets abort=1 ->WB.
- WB (1 cycle): o_pc_wren=1; o_pc_sel=1 for JAL/JALR/taken branch (abort forces 0); o_rd_wren=1 for R,I,load,JAL,JALR,LUI,AUIPC unless abort; wb_sel: load 01, JAL/JALR 10, LUI 11, else 00 (AUIPC = PC+imm via ALU). o_insn_vld=1 and instret+1 only if !abort. ->FETCH, abort/taken cleared.
- Latency: 4 cycles (5 with MEM) at zero-wait memory. instret wraps FFFF_FFFF->0.

Decomposition:
- Package mc_pkg: state enum, opcode, alu_op and wb_sel localparams.
- Sub-module mc_decode: combinational IR -> static datapath controls and legal flag.

Test Plan:
- add x3,x1,x2 zero-wait ack -> FETCH..WB 4 cycles; WB: rd_wren=1, alu_op=0000, wb_sel=00, insn_vld=1, instret=1.
- bltu with i_br_less=1 -> br_un=1 in EXEC, pc_sel=1 in WB; bge with i_br_less=1 -> pc_sel=0.
- lw, dmem ack after 3 cycles -> o_dmem_req held 4 cycles, mem_wren=0, WB wb_sel=01; sw -> mem_wren=1, rd_wren=0.
- dmem never acks, TIMEOUT=16 -> o_bus_err pulse 16th MEM cycle, WB rd_wren=0, pc_sel=0, insn_vld=0, instret unchanged.
- IR=32'hFFFF_FFFF -> o_illegal pulse in DECODE, WB pc_wren=1 only; i_rst_n low mid-MEM -> o_dmem_req drops immediately, IR=NOP, FETCH.
